// File: rtl/mutex_rule_scheduler.sv
// mutex_rule_scheduler: picks one enabled rule per cycle for the mutual-
// exclusion `system` model, round-robin with a starvation override.
//
// Ports:
//   clock            rising-edge clock for all state
//   reset            asynchronous, active-low; clears all state at once
//   io_req           per-process "has an enabled rule" request vector
//   io_hold          freeze: no grant, pointer and counters hold
//   io_clear_starve  clears the sticky starvation flags on this edge
//   io_en_a          registered one-hot (or zero) rule enable
//   io_en_valid      registered, equals |io_en_a
//   io_starve        sticky per-process starvation flags
//   io_grant_idx     registered index of the granted process (0 if none)
module mutex_rule_scheduler #(
  parameter int N_PROC       = 3,
  parameter int STARVE_LIMIT = 6,
  parameter int CNT_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_PROC-1:0] io_req,
  input  logic              io_hold,
  input  logic              io_clear_starve,
  output logic [N_PROC-1:0] io_en_a,
  output logic              io_en_valid,
  output logic [N_PROC-1:0] io_starve,
  output logic [1:0]        io_grant_idx
);

  localparam int IDX_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

  // Registered state
  logic [N_PROC-1:0] en_q,        en_d;
  logic              en_valid_q,  en_valid_d;
  logic [1:0]        grant_idx_q, grant_idx_d;
  logic [N_PROC-1:0] starve_q,    starve_d;
  logic [IDX_W-1:0]  ptr_q,       ptr_d;
  logic [CNT_W-1:0]  cnt_q [N_PROC];
  logic [CNT_W-1:0]  cnt_d [N_PROC];

  // Arbitration intermediates
  logic [N_PROC-1:0]   starving;
  logic                s_found;
  logic [IDX_W-1:0]    s_idx;
  logic [2*N_PROC-1:0] req_rot;
  logic                rr_found;
  logic [IDX_W-1:0]    rr_idx;
  logic                grant_valid;
  logic [IDX_W-1:0]    g_idx;
  logic [N_PROC-1:0]   grant_oh;
  logic [N_PROC-1:0]   set_ev;

  // (a + k) mod N_PROC for a < N_PROC and 0 <= k < N_PROC
  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input int               k
  );
    logic [IDX_W:0] s;
    s = {1'b0, a} + (IDX_W+1)'(k);
    if (s >= (IDX_W+1)'(N_PROC))
      s = s - (IDX_W+1)'(N_PROC);
    return s[IDX_W-1:0];
  endfunction

  // Starving set and its lowest member
  always_comb begin
    starving = '0;
    s_found  = 1'b0;
    s_idx    = '0;
    for (int i = 0; i < N_PROC; i++)
      starving[i] = io_req[i] && (cnt_q[i] >= LIMIT);
    // Descending scan so the lowest index is the last one written
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (starving[i]) begin
        s_found = 1'b1;
        s_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin pick: rotate so bit k is process (ptr+k) mod N_PROC
  always_comb begin
    req_rot  = {io_req, io_req} >> ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = N_PROC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // Final grant selection
  always_comb begin
    grant_valid = s_found || rr_found;
    g_idx       = s_found ? s_idx : rr_idx;
    grant_oh    = '0;
    if (grant_valid)
      grant_oh = N_PROC'(1) << g_idx;
  end

  // Next-state logic
  always_comb begin
    en_d        = '0;
    en_valid_d  = 1'b0;
    grant_idx_d = '0;
    ptr_d       = ptr_q;
    starve_d    = starve_q;
    set_ev      = '0;
    for (int i = 0; i < N_PROC; i++)
      cnt_d[i] = cnt_q[i];

    if (!io_hold) begin
      if (grant_valid) begin
        en_d        = grant_oh;
        en_valid_d  = 1'b1;
        grant_idx_d = 2'(g_idx);
        ptr_d       = wrap_add(g_idx, 1);
      end
      for (int i = 0; i < N_PROC; i++) begin
        if (grant_oh[i])
          cnt_d[i] = '0;
        else if (io_req[i])
          cnt_d[i] = (cnt_q[i] == CNT_MAX) ? CNT_MAX
                                           : cnt_q[i] + 1'b1;
        else
          // A withdrawn request forgets its waiting history
          cnt_d[i] = '0;
        set_ev[i] = (cnt_d[i] == LIMIT) && (cnt_q[i] != LIMIT);
      end
    end

    // A flag being set on the same edge as a clear stays set
    if (io_clear_starve)
      starve_d = '0;
    starve_d = starve_d | set_ev;
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q        <= '0;
      en_valid_q  <= 1'b0;
      grant_idx_q <= '0;
      starve_q    <= '0;
      ptr_q       <= '0;
      for (int i = 0; i < N_PROC; i++)
        cnt_q[i] <= '0;
    end else begin
      en_q        <= en_d;
      en_valid_q  <= en_valid_d;
      grant_idx_q <= grant_idx_d;
      starve_q    <= starve_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < N_PROC; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign io_en_a      = en_q;
  assign io_en_valid  = en_valid_q;
  assign io_starve    = starve_q;
  assign io_grant_idx = grant_idx_q;

endmodule
